// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e          : sequencer FSM states (reset, free run, halted, debug step)
//   FWD_*            : operand forwarding select encodings
//   GPR_ZERO         : hard-wired zero register, never forwarded or stalled on
//   STG_*            : bit positions inside the {IF,ID,EXE,MEM,WB} stage vectors
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_STEP = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF   = 2'd0;  // register file
    localparam logic [1:0] FWD_EXE  = 2'd1;  // alu_out_exe
    localparam logic [1:0] FWD_MEM  = 2'd2;  // alu_out_mem
    localparam logic [1:0] FWD_MDIN = 2'd3;  // mem_din (load data)

    localparam logic [4:0] GPR_ZERO = 5'd0;

    localparam int unsigned STG_IF  = 4;
    localparam int unsigned STG_ID  = 3;
    localparam int unsigned STG_EXE = 2;
    localparam int unsigned STG_MEM = 1;
    localparam int unsigned STG_WB  = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the decoder/datapath and the hazard controller.
//   slave  : the controller (takes ID/EXE/MEM hazard info, drives stage controls)
//   master : the decoder/datapath side (drives hazard info, consumes controls)
// With PIPE_PERF_CNT_EN defined the bundle also carries three 32-bit counters.
interface pipe_hazard_ctrl_if;

    logic       cpu_en;
    logic       cpu_step;
    logic       dmem_wait;
    logic [4:0] addr_rs_id;
    logic [4:0] addr_rt_id;
    logic       rs_used_id;
    logic       rt_used_id;
    logic       rt_store_id;
    logic       is_branch;
    logic       is_not_taken;
    logic [4:0] regw_addr_exe;
    logic [4:0] regw_addr_mem;
    logic       wb_wen_exe;
    logic       wb_wen_mem;
    logic       mem_ren_exe;
    logic       mem_ren_mem;

    logic       if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic       if_en, id_en, exe_en, mem_en, wb_en;
    logic [1:0] exe_fwd_a_ctrl;
    logic [1:0] exe_fwd_b_ctrl;
    logic       fwd_m;
    logic       stall_ld;
    logic       flush_br;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stalls;
    logic [31:0] perf_flushes;
`endif

    modport slave (
        input  cpu_en, cpu_step, dmem_wait, addr_rs_id, addr_rt_id, rs_used_id, rt_used_id,
               rt_store_id, is_branch, is_not_taken, regw_addr_exe, regw_addr_mem,
               wb_wen_exe, wb_wen_mem, mem_ren_exe, mem_ren_mem,
        output if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en,
               exe_fwd_a_ctrl, exe_fwd_b_ctrl, fwd_m, stall_ld, flush_br
`ifdef PIPE_PERF_CNT_EN
        , output perf_cycles, perf_stalls, perf_flushes
`endif
    );

    modport master (
        output cpu_en, cpu_step, dmem_wait, addr_rs_id, addr_rt_id, rs_used_id, rt_used_id,
               rt_store_id, is_branch, is_not_taken, regw_addr_exe, regw_addr_mem,
               wb_wen_exe, wb_wen_mem, mem_ren_exe, mem_ren_mem,
        input  if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en,
               exe_fwd_a_ctrl, exe_fwd_b_ctrl, fwd_m, stall_ld, flush_br
`ifdef PIPE_PERF_CNT_EN
        , input perf_cycles, perf_stalls, perf_flushes
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one ID-stage source operand.
//   addr                      : register the operand reads
//   regw_addr_*/wb_wen_*      : destination and write enable of EXE / MEM instructions
//   mem_ren_*                 : EXE / MEM instruction is a load
//   sel                       : FWD_RF / FWD_EXE / FWD_MEM / FWD_MDIN
module pipe_hazard_ctrl_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] addr,
    input  logic [4:0] regw_addr_exe,
    input  logic       wb_wen_exe,
    input  logic       mem_ren_exe,
    input  logic [4:0] regw_addr_mem,
    input  logic       wb_wen_mem,
    input  logic       mem_ren_mem,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (addr != GPR_ZERO) begin
            // A load in EXE has no data yet; that case is a stall, not a forward.
            if (wb_wen_exe && regw_addr_exe == addr && !mem_ren_exe) begin
                sel = FWD_EXE;
            end else if (wb_wen_mem && regw_addr_mem == addr) begin
                sel = mem_ren_mem ? FWD_MDIN : FWD_MEM;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS datapath: per-stage clear/enable pairs,
// operand forwarding selects, load-use stall, taken-branch flush, data-memory wait
// freeze and a run/halt/single-step debug FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   hz         : pipe_hazard_ctrl_if.slave (hazard inputs in, stage controls out)
// Parameter STEP_HOLD (1..15): pipeline advances per cpu_step pulse while halted.
// Optional macro PIPE_PERF_CNT_EN adds perf_cycles/perf_stalls/perf_flushes.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned STEP_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [3:0] StepLoad = 4'(STEP_HOLD);

    state_e     state_q, state_d;
    logic [3:0] step_cnt_q, step_cnt_d;
    logic       st_exe_q, st_mem_q;  // store-data-from-load flag in EXE / MEM

    logic       active;
    logic       load_exe;
    logic       hazard_ld;
    logic       stall_ld;
    logic       flush_br;
    logic       st_id;
    logic [4:0] stage_rst;
    logic [4:0] stage_en;
    logic [1:0] fwd_a, fwd_b;

    pipe_hazard_ctrl_fwd_sel u_fwd_rs (
        .addr          (hz.addr_rs_id),
        .regw_addr_exe (hz.regw_addr_exe),
        .wb_wen_exe    (hz.wb_wen_exe),
        .mem_ren_exe   (hz.mem_ren_exe),
        .regw_addr_mem (hz.regw_addr_mem),
        .wb_wen_mem    (hz.wb_wen_mem),
        .mem_ren_mem   (hz.mem_ren_mem),
        .sel           (fwd_a)
    );

    pipe_hazard_ctrl_fwd_sel u_fwd_rt (
        .addr          (hz.addr_rt_id),
        .regw_addr_exe (hz.regw_addr_exe),
        .wb_wen_exe    (hz.wb_wen_exe),
        .mem_ren_exe   (hz.mem_ren_exe),
        .regw_addr_mem (hz.regw_addr_mem),
        .wb_wen_mem    (hz.wb_wen_mem),
        .mem_ren_mem   (hz.mem_ren_mem),
        .sel           (fwd_b)
    );

    assign active    = (state_q == S_RUN) || (state_q == S_STEP);
    assign load_exe  = hz.wb_wen_exe && hz.mem_ren_exe && (hz.regw_addr_exe != GPR_ZERO);
    assign hazard_ld = load_exe &&
                       ((hz.rs_used_id && hz.addr_rs_id == hz.regw_addr_exe) ||
                        (hz.rt_used_id && hz.addr_rt_id == hz.regw_addr_exe));
    assign stall_ld  = active && hazard_ld;
    // A stalled branch re-evaluates next cycle, so it must not flush now.
    assign flush_br  = active && hz.is_branch && !hz.is_not_taken && !hazard_ld;
    // sw whose data comes from the load in EXE: no stall, data picked from WB later.
    assign st_id     = hz.rt_store_id && load_exe && (hz.addr_rt_id == hz.regw_addr_exe);

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            S_RST:  state_d = hz.cpu_en ? S_RUN : S_HALT;
            S_RUN:  if (!hz.cpu_en) state_d = S_HALT;
            S_HALT: begin
                if (hz.cpu_en) begin
                    state_d = S_RUN;
                end else if (hz.cpu_step) begin
                    state_d    = S_STEP;
                    step_cnt_d = StepLoad;
                end
            end
            S_STEP: begin
                // Only real advances consume the step budget.
                if (!hz.dmem_wait) begin
                    step_cnt_d = step_cnt_q - 4'd1;
                    if (step_cnt_q <= 4'd1) state_d = S_HALT;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        stage_rst = '0;
        stage_en  = '0;
        if (state_q == S_RST) begin
            stage_rst = '1;
        end else if (active && !hz.dmem_wait) begin
            stage_en = '1;
            if (hazard_ld) begin
                stage_en[STG_IF]   = 1'b0;
                stage_en[STG_ID]   = 1'b0;
                stage_rst[STG_EXE] = 1'b1;
            end else if (flush_br) begin
                stage_rst[STG_ID] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RST;
            step_cnt_q <= '0;
            st_exe_q   <= 1'b0;
            st_mem_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            if (stage_rst[STG_EXE])     st_exe_q <= 1'b0;
            else if (stage_en[STG_EXE]) st_exe_q <= st_id;
            if (stage_rst[STG_MEM])     st_mem_q <= 1'b0;
            else if (stage_en[STG_MEM]) st_mem_q <= st_exe_q;
        end
    end

    assign hz.if_rst  = stage_rst[STG_IF];
    assign hz.id_rst  = stage_rst[STG_ID];
    assign hz.exe_rst = stage_rst[STG_EXE];
    assign hz.mem_rst = stage_rst[STG_MEM];
    assign hz.wb_rst  = stage_rst[STG_WB];
    assign hz.if_en   = stage_en[STG_IF];
    assign hz.id_en   = stage_en[STG_ID];
    assign hz.exe_en  = stage_en[STG_EXE];
    assign hz.mem_en  = stage_en[STG_MEM];
    assign hz.wb_en   = stage_en[STG_WB];

    assign hz.exe_fwd_a_ctrl = (state_q == S_RST) ? FWD_RF : fwd_a;
    assign hz.exe_fwd_b_ctrl = (state_q == S_RST) ? FWD_RF : fwd_b;
    assign hz.fwd_m          = st_mem_q;
    assign hz.stall_ld       = stall_ld;
    assign hz.flush_br       = flush_br;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_stalls_q, perf_flushes_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q  <= '0;
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else if (!hz.dmem_wait) begin
            if (active)   perf_cycles_q  <= perf_cycles_q + 32'd1;
            if (stall_ld) perf_stalls_q  <= perf_stalls_q + 32'd1;
            if (flush_br) perf_flushes_q <= perf_flushes_q + 32'd1;
        end
    end

    assign hz.perf_cycles  = perf_cycles_q;
    assign hz.perf_stalls  = perf_stalls_q;
    assign hz.perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (STEP_HOLD = 2): reset sequence, a
// table of single-cycle hazard vectors, hand-written multi-cycle sequences and a
// randomized run against a behavioural reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned STEP_HOLD = 2;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_u;
        logic       rt_u;
        logic       rt_st;
        logic       br;
        logic       nt;
        logic [4:0] wa_e;
        logic       we_e;
        logic       re_e;
        logic [4:0] wa_m;
        logic       we_m;
        logic       re_m;
    } hz_in_t;

    typedef struct {
        hz_in_t     in;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       fl;
        logic [3:0] stg;  // {if_en, id_en, exe_rst, id_rst}
    } vec_t;

    localparam logic [18:0] M_ALL   = 19'h7FFFF;
    localparam logic [18:0] M_STAGE = 19'h7FE00;
    localparam logic [18:0] M_NOFM  = 19'h7FFFB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.STEP_HOLD(STEP_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    logic [18:0] obs_v;
    assign obs_v = {hz.if_rst, hz.id_rst, hz.exe_rst, hz.mem_rst, hz.wb_rst,
                    hz.if_en, hz.id_en, hz.exe_en, hz.mem_en, hz.wb_en,
                    hz.exe_fwd_a_ctrl, hz.exe_fwd_b_ctrl, hz.fwd_m, hz.stall_ld, hz.flush_br};

    int n_vec = 0;
    int n_err = 0;
    vec_t tab[$];

    // Model state for the random phase.
    bit m_rst;
    bit m_run;
    int m_steps;
    bit m_st_exe, m_st_mem;

    function automatic logic [18:0] mk(input logic [4:0] r, input logic [4:0] e,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic fm, input logic st, input logic fl);
        return {r, e, fa, fb, fm, st, fl};
    endfunction

    function automatic hz_in_t mkin(input int rs, input int rt, input bit rs_u, input bit rt_u,
                                    input bit rt_st, input bit br, input bit nt,
                                    input int wa_e, input bit we_e, input bit re_e,
                                    input int wa_m, input bit we_m, input bit re_m);
        hz_in_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.rs_u = rs_u; v.rt_u = rt_u; v.rt_st = rt_st;
        v.br = br; v.nt = nt; v.wa_e = 5'(wa_e); v.we_e = we_e; v.re_e = re_e;
        v.wa_m = 5'(wa_m); v.we_m = we_m; v.re_m = re_m;
        return v;
    endfunction

    task automatic drive(input hz_in_t v);
        hz.addr_rs_id    = v.rs;
        hz.addr_rt_id    = v.rt;
        hz.rs_used_id    = v.rs_u;
        hz.rt_used_id    = v.rt_u;
        hz.rt_store_id   = v.rt_st;
        hz.is_branch     = v.br;
        hz.is_not_taken  = v.nt;
        hz.regw_addr_exe = v.wa_e;
        hz.wb_wen_exe    = v.we_e;
        hz.mem_ren_exe   = v.re_e;
        hz.regw_addr_mem = v.wa_m;
        hz.wb_wen_mem    = v.we_m;
        hz.mem_ren_mem   = v.re_m;
    endtask

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp,
                         input logic [18:0] mask);
        n_vec++;
        if ((got & mask) !== (exp & mask)) begin
            n_err++;
            $display("FAIL %s @%0t: got %b required %b (mask %b)", name, $time, got, exp, mask);
        end
    endtask

    task automatic add(input hz_in_t in, input logic [1:0] fa, input logic [1:0] fb,
                       input logic st, input logic fl, input logic [3:0] stg);
        vec_t v;
        v.in = in; v.fa = fa; v.fb = fb; v.st = st; v.fl = fl; v.stg = stg;
        tab.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] x, input hz_in_t v);
        if (x == 5'd0) return 2'd0;
        if (v.we_e && v.wa_e == x && !v.re_e) return 2'd1;
        if (v.we_m && v.wa_m == x) return v.re_m ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    // Reference outputs from the model state and this cycle's inputs.
    task automatic model_eval(input hz_in_t v, input bit wt, output logic [4:0] r,
                              output logic [4:0] e, output logic [18:0] vec);
        bit active, ld, haz, st, fl;
        logic [1:0] fa, fb;
        active = !m_rst && (m_run || m_steps > 0);
        ld  = v.we_e && v.re_e && v.wa_e != 5'd0;
        haz = ld && ((v.rs_u && v.rs == v.wa_e) || (v.rt_u && v.rt == v.wa_e));
        st  = active && haz;
        fl  = active && v.br && !v.nt && !haz;
        r = 5'b00000;
        e = 5'b00000;
        if (m_rst) begin
            r = 5'b11111;
        end else if (active && !wt) begin
            e = 5'b11111;
            if (haz) begin
                e = 5'b00111;
                r = 5'b00100;
            end else if (fl) begin
                r = 5'b01000;
            end
        end
        fa = m_rst ? 2'd0 : ref_fwd(v.rs, v);
        fb = m_rst ? 2'd0 : ref_fwd(v.rt, v);
        vec = mk(r, e, fa, fb, m_st_mem, st, fl);
    endtask

    initial begin
        hz_in_t zero_in, ld_use, cur;
        logic [6:0] wait_pat, adv_pat;
        int adv;
        logic [4:0] er, ee;
        logic [18:0] ev;
        bit idf;

        zero_in = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld_use  = mkin(8, 2, 1, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0);

        // ---- reset and run; forward inputs present to check gating in reset
        rst_n = 1'b0;
        hz.cpu_en = 1'b1; hz.cpu_step = 1'b0; hz.dmem_wait = 1'b0;
        drive(mkin(5, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0));
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", obs_v, mk(5'h1F, 5'h00, 0, 0, 0, 0, 0), M_ALL);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_extra_cycle", obs_v, mk(5'h1F, 5'h00, 0, 0, 0, 0, 0), M_ALL);
        next_cycle();
        @(negedge clk);
        check("run_after_reset", obs_v, mk(5'h00, 5'h1F, 1, 0, 0, 0, 0), M_ALL);

        // ---- single-cycle vector table (free run)
        add(mkin(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 4'b1100);
        add(mkin(5, 6, 1, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0), 1, 0, 0, 0, 4'b1100);
        add(mkin(5, 6, 1, 1, 0, 0, 0, 3, 1, 0, 5, 1, 0), 2, 0, 0, 0, 4'b1100);
        add(mkin(5, 5, 1, 1, 0, 0, 0, 5, 1, 0, 5, 1, 0), 1, 1, 0, 0, 4'b1100);
        add(mkin(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 7, 1, 1), 0, 3, 0, 0, 4'b1100);
        add(mkin(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1), 0, 0, 0, 0, 4'b1100);
        add(mkin(9, 2, 1, 1, 0, 0, 0, 9, 0, 0, 9, 1, 0), 2, 0, 0, 0, 4'b1100);
        add(mkin(8, 2, 1, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0), 0, 0, 1, 0, 4'b0010);
        add(mkin(8, 2, 0, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0), 0, 0, 0, 0, 4'b1100);
        add(mkin(1, 8, 1, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0), 0, 0, 1, 0, 4'b0010);
        add(mkin(1, 8, 1, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0), 0, 0, 0, 0, 4'b1100);
        add(mkin(1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 4'b1101);
        add(mkin(1, 2, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 4'b1100);
        add(mkin(8, 2, 1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0), 0, 0, 1, 0, 4'b0010);
        add(mkin(0, 2, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0), 0, 0, 0, 0, 4'b1100);
        add(mkin(4, 2, 0, 1, 0, 0, 0, 4, 1, 1, 4, 1, 0), 2, 0, 0, 0, 4'b1100);
        add(mkin(8, 2, 1, 1, 0, 0, 0, 8, 0, 1, 0, 0, 0), 0, 0, 0, 0, 4'b1100);
        foreach (tab[i]) begin
            next_cycle();
            drive(tab[i].in);
            @(negedge clk);
            check($sformatf("table_%0d", i), obs_v,
                  mk({1'b0, tab[i].stg[0], tab[i].stg[1], 2'b00},
                     {tab[i].stg[3], tab[i].stg[2], 3'b111},
                     tab[i].fa, tab[i].fb, 1'b0, tab[i].st, tab[i].fl), M_NOFM);
        end

        // ---- load-use: one stall cycle, then load data forwarded from MEM
        next_cycle(); drive(ld_use);
        @(negedge clk);
        check("ld_use_stall", obs_v, mk(5'b00100, 5'b00111, 0, 0, 0, 1, 0), M_ALL);
        next_cycle(); drive(mkin(8, 2, 1, 1, 0, 0, 0, 0, 0, 0, 8, 1, 1));
        @(negedge clk);
        check("ld_use_resolved", obs_v, mk(5'h00, 5'h1F, 3, 0, 0, 0, 0), M_ALL);

        // ---- store after load: no stall, fwd_m exactly two cycles later
        next_cycle(); drive(mkin(1, 8, 1, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0));
        @(negedge clk);
        check("st_ld_nostall", obs_v, mk(5'h00, 5'h1F, 0, 0, 0, 0, 0), M_ALL);
        next_cycle(); drive(zero_in);
        @(negedge clk);
        check("st_ld_cyc1", obs_v, mk(5'h00, 5'h1F, 0, 0, 0, 0, 0), M_ALL);
        next_cycle();
        @(negedge clk);
        check("st_ld_fwd_m", obs_v, mk(5'h00, 5'h1F, 0, 0, 1, 0, 0), M_ALL);
        next_cycle();
        @(negedge clk);
        check("st_ld_cyc3", obs_v, mk(5'h00, 5'h1F, 0, 0, 0, 0, 0), M_ALL);

        // ---- taken branch behind a load-use: stall first, flush next
        next_cycle(); drive(mkin(8, 2, 1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0));
        @(negedge clk);
        check("br_ld_stall", obs_v, mk(5'b00100, 5'b00111, 0, 0, 0, 1, 0), M_ALL);
        next_cycle(); drive(mkin(8, 2, 1, 1, 0, 1, 0, 0, 0, 0, 8, 1, 1));
        @(negedge clk);
        check("br_ld_flush", obs_v, mk(5'b01000, 5'h1F, 3, 0, 0, 0, 1), M_ALL);

        // ---- dmem_wait freezes everything, then stall / flush reassert
        next_cycle(); drive(ld_use); hz.dmem_wait = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("wait_over_stall", obs_v, mk(5'h00, 5'h00, 0, 0, 0, 0, 0), M_STAGE);
            next_cycle();
        end
        hz.dmem_wait = 1'b0;
        @(negedge clk);
        check("stall_after_wait", obs_v, mk(5'b00100, 5'b00111, 0, 0, 0, 1, 0), M_ALL);
        next_cycle(); drive(mkin(1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0)); hz.dmem_wait = 1'b1;
        @(negedge clk);
        check("wait_over_flush", obs_v, mk(5'h00, 5'h00, 0, 0, 0, 0, 0), M_STAGE);
        next_cycle(); hz.dmem_wait = 1'b0;
        @(negedge clk);
        check("flush_after_wait", obs_v, mk(5'b01000, 5'h1F, 0, 0, 0, 0, 1), M_ALL);

        // ---- debug: halt, one step of STEP_HOLD=2 advances with a 3-cycle wait inside
        next_cycle(); drive(zero_in); hz.cpu_en = 1'b0;
        @(negedge clk);
        check("halt_req_cycle", obs_v, mk(5'h00, 5'h1F, 0, 0, 0, 0, 0), M_ALL);
        next_cycle();
        @(negedge clk);
        check("halted", obs_v, mk(5'h00, 5'h00, 0, 0, 0, 0, 0), M_ALL);
        next_cycle(); hz.cpu_step = 1'b1;
        @(negedge clk);
        check("halted_step_pulse", obs_v, mk(5'h00, 5'h00, 0, 0, 0, 0, 0), M_ALL);
        wait_pat = 7'b0001110;
        adv_pat  = 7'b0010001;
        adv = 0;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            hz.dmem_wait = wait_pat[i];
            hz.cpu_step  = (i == 2);  // must be ignored mid-step
            @(negedge clk);
            check($sformatf("step_cyc%0d", i), obs_v,
                  mk(5'h00, adv_pat[i] ? 5'h1F : 5'h00, 0, 0, 0, 0, 0), M_STAGE);
            if (hz.if_en === 1'b1) adv++;
        end
        n_vec++;
        if (adv != int'(STEP_HOLD)) begin
            n_err++;
            $display("FAIL step_advance_count: got %0d required %0d", adv, STEP_HOLD);
        end

        // ---- randomized run against the reference model
        next_cycle();
        rst_n = 1'b0; hz.cpu_en = 1'b1; hz.cpu_step = 1'b0; hz.dmem_wait = 1'b0;
        drive(zero_in);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        m_rst = 1'b1; m_run = 1'b0; m_steps = 0; m_st_exe = 1'b0; m_st_mem = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            cur = mkin($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 1));
            drive(cur);
            if ($urandom_range(0, 19) == 0) hz.cpu_en = ~hz.cpu_en;
            hz.cpu_step  = ($urandom_range(0, 7) == 0);
            hz.dmem_wait = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            model_eval(cur, hz.dmem_wait, er, ee, ev);
            check("random", obs_v, ev, M_ALL);
            @(posedge clk);
            // Store flag follows the instruction through EXE and MEM.
            idf = cur.rt_st && cur.we_e && cur.re_e && cur.wa_e != 5'd0 && cur.rt == cur.wa_e;
            if (er[1])      m_st_mem = 1'b0;
            else if (ee[1]) m_st_mem = m_st_exe;
            if (er[2])      m_st_exe = 1'b0;
            else if (ee[2]) m_st_exe = idf;
            if (m_rst) begin
                m_rst = 1'b0; m_run = hz.cpu_en; m_steps = 0;
            end else if (m_run) begin
                m_run = hz.cpu_en;
            end else if (m_steps > 0) begin
                if (!hz.dmem_wait) m_steps--;
            end else if (hz.cpu_en) begin
                m_run = 1'b1;
            end else if (hz.cpu_step) begin
                m_steps = STEP_HOLD;
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
